// File: rtl/module_uart_host_bridge.sv
// rtl/module_uart_host_bridge.sv - byte-stream bridge driving the UART peripheral host register port
// Holds a TX and an RX byte FIFO and sequences control/data register accesses from a polling FSM.

module uart_host_bridge_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] push_data_i,
  input  logic       push_valid_i,
  output logic       push_ready_o,
  output logic [7:0] pop_data_o,
  output logic       pop_valid_o,
  input  logic       pop_ready_i
);

  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push;
  logic          pop;

  assign push_ready_o = (count_q != (AW+1)'(DEPTH));
  assign pop_valid_o  = (count_q != '0);
  // Head is only exposed once stored, and reads as zero while empty.
  assign pop_data_o   = pop_valid_o ? mem_q[rd_ptr_q] : 8'h00;

  always_comb begin
    push     = push_valid_i && push_ready_o;
    pop      = pop_ready_i && pop_valid_o;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data_i;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

module module_uart_host_bridge #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  tx_data_i,
  input  logic        tx_valid_i,
  output logic        tx_ready_o,
  output logic [7:0]  rx_data_o,
  output logic        rx_valid_o,
  input  logic        rx_ready_i,
  output logic        tx_idle_o,
  output logic        wr_o,
  output logic        reg_sel_o,
  output logic        addr_o,
  output logic [31:0] data_o,
  input  logic [31:0] data_i
);

  typedef enum logic [2:0] {
    ST_POLL,
    ST_RX_READ,
    ST_RX_CLR,
    ST_TX_LOAD,
    ST_TX_GO
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] status_q, status_d;
  logic [7:0] tx_head;
  logic       tx_not_empty;
  logic       tx_pop;
  logic       rx_push;
  logic       rx_not_full;
  logic       unused_bits;

  assign unused_bits = ^{data_i[31:8], status_q[1]};

  uart_host_bridge_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_data_i (tx_data_i),
    .push_valid_i(tx_valid_i),
    .push_ready_o(tx_ready_o),
    .pop_data_o  (tx_head),
    .pop_valid_o (tx_not_empty),
    .pop_ready_i (tx_pop)
  );

  uart_host_bridge_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_data_i (data_i[7:0]),
    .push_valid_i(rx_push),
    .push_ready_o(rx_not_full),
    .pop_data_o  (rx_data_o),
    .pop_valid_o (rx_valid_o),
    .pop_ready_i (rx_ready_i)
  );

  assign tx_idle_o = !tx_not_empty && !status_q[0];

  always_comb begin
    state_d   = state_q;
    status_d  = status_q;
    wr_o      = 1'b0;
    reg_sel_o = 1'b0;
    addr_o    = 1'b0;
    data_o    = 32'h0000_0000;
    tx_pop    = 1'b0;
    rx_push   = 1'b0;
    case (state_q)
      ST_POLL: begin
        status_d = data_i[1:0];
        // RX wins so a pending byte is drained before the peripheral can overwrite it.
        if (data_i[1] && rx_not_full) begin
          state_d = ST_RX_READ;
        end else if (!data_i[0] && tx_not_empty) begin
          state_d = ST_TX_LOAD;
        end
      end
      ST_RX_READ: begin
        reg_sel_o = 1'b1;
        addr_o    = 1'b1;
        rx_push   = 1'b1;
        state_d   = ST_RX_CLR;
      end
      ST_RX_CLR: begin
        wr_o    = 1'b1;
        data_o  = {31'b0, data_i[0]};
        state_d = ST_POLL;
      end
      ST_TX_LOAD: begin
        wr_o      = 1'b1;
        reg_sel_o = 1'b1;
        data_o    = {24'b0, tx_head};
        tx_pop    = 1'b1;
        state_d   = ST_TX_GO;
      end
      ST_TX_GO: begin
        // Control write keeps a NEW_RX that arrived meanwhile, so it is not lost.
        wr_o    = 1'b1;
        data_o  = {30'b0, data_i[1], 1'b1};
        state_d = ST_POLL;
      end
      default: begin
        state_d = ST_POLL;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= ST_POLL;
      status_q <= 2'b00;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
    end
  end

endmodule

// File: doc/module_uart_host_bridge.md
# module_uart_host_bridge

Register-bus master that drives the UART peripheral's host port (`wr`, `reg_sel`, `addr`, 32-bit data in/out) on behalf of byte-stream clients. It buffers outgoing bytes in a TX FIFO and incoming bytes in an RX FIFO, polls the peripheral control register, and runs the load/send and read/clear register sequences. Clients see only valid/ready byte streams. It sits directly upstream of the UART peripheral top, in the same 10 MHz clock domain.

## Interface
- `FIFO_DEPTH`, 8: entries per FIFO; power of two, ≥ 2.
- `clk_i` in 1: system clock (10 MHz).
- `rst_i` in 1: asynchronous, active-low reset.
- `tx_data_i` in 8: byte to transmit.
- `tx_valid_i` in 1: `tx_data_i` valid.
- `tx_ready_o` out 1: TX FIFO not full.
- `rx_data_o` out 8: received byte at RX FIFO head.
- `rx_valid_o` out 1: RX FIFO not empty.
- `rx_ready_i` in 1: client consumes the head byte.
- `tx_idle_o` out 1: TX FIFO empty, and last polled control bit0 = 0.
- `wr_o` out 1: peripheral write strobe.
- `reg_sel_o` out 1: 0 = control register, 1 = data register.
- `addr_o` out 1: data-register address; 0 = TX byte, 1 = RX byte.
- `data_o` out 32: peripheral write data.
- `data_i` in 32: peripheral read data. Combinational: valid in the same cycle as `reg_sel_o`/`addr_o`.

## Operation
- Peripheral control register:
  - bit0 = SEND. Host sets it; peripheral clears it when the frame is done.
  - bit1 = NEW_RX. Peripheral sets it on byte receipt; host clears it.
- FIFOs: synchronous; count width log2(FIFO_DEPTH)+1.
  - Push on valid&ready.
  - Push and pop in the same cycle are both honoured, count unchanged.
  - No write-through: an empty FIFO never presents a byte in the push cycle.
- FSM states:
  - POLL: `reg_sel_o`=0, `wr_o`=0. Register `data_i[1:0]` as {nrx, busy}.
    - If nrx=1 and RX FIFO not full → RX_READ.
    - Else if busy=0 and TX FIFO not empty → TX_LOAD.
    - Else stay in POLL.
  - RX_READ: `reg_sel_o`=1, `addr_o`=1, `wr_o`=0. Push `data_i[7:0]` into RX FIFO → RX_CLR.
  - RX_CLR: `reg_sel_o`=0, `wr_o`=1, `data_o`={30'b0, 1'b0, `data_i[0]`} (live SEND preserved) → POLL.
  - TX_LOAD: `reg_sel_o`=1, `addr_o`=0, `wr_o`=1, `data_o`={24'b0, TX head}. Pop TX FIFO → TX_GO.
  - TX_GO: `reg_sel_o`=0, `wr_o`=1, `data_o`={30'b0, `data_i[1]`, 1'b1} (live NEW_RX preserved) → POLL.
- Priority: RX service beats TX.
- RX FIFO full with NEW_RX set: flag left set, no read. TX service proceeds. Peripheral-side overwrite of the byte is accepted loss.
- Bus outputs decode from registered state only, plus the live `data_i` bits noted above. No other combinational path from `data_i` to outputs.

## Timing
- Reset values:
  - State POLL.
  - `wr_o`=0, `reg_sel_o`=0, `addr_o`=0, `data_o`=0.
  - Both FIFOs empty: `tx_ready_o`=1, `rx_valid_o`=0, `rx_data_o`=0.
  - {nrx, busy}=0, `tx_idle_o`=1.
- Reset mid-sequence: state returns to POLL immediately.
  - An RX byte read but not yet cleared stays flagged and is re-read after reset.
  - A popped TX byte whose TX_GO was lost is dropped.
- TX latency: byte accepted at edge k, bridge in POLL → POLL at k+1, TX_LOAD at k+2, TX_GO at k+3. Next TX attempt only after a POLL sees busy=0.
- RX latency: POLL at cycle p sees nrx=1 → RX_READ at p+1, `rx_valid_o` high at p+2 (RX_CLR), POLL at p+3.
- Bus sequences are 1 cycle per state, with no wait states. Every sequence ends in POLL.

## Test plan
- Reset with TX FIFO empty → `wr_o`=0, `reg_sel_o`=0, `tx_ready_o`=1, `rx_valid_o`=0, `tx_idle_o`=1; bus stays in POLL.
- Push 0xA5 while `data_i`=0 → TX_LOAD writes 0x000000A5 (`reg_sel_o`=1, `addr_o`=0), next cycle writes 0x00000001 to control. No further TX while `data_i[0]`=1.
- Push 8 bytes 0x01..0x08 (depth 8) → `tx_ready_o`=0 after the 8th. Bytes appear on the bus in order, each only after a POLL with bit0=0.
- Assert `data_i[1]`=1 with RX data 0x3C → RX_READ, RX_CLR writes 0x00000000. `rx_valid_o`=1 with `rx_data_o`=0x3C two cycles after the POLL.
- NEW_RX set during TX_GO (`data_i`=0x2) → `data_o`=0x00000003. Flag is serviced at the next POLL before any TX.
- RX FIFO full, `rx_ready_i`=0, NEW_RX=1, TX byte pending → no RX_READ; TX proceeds. After one pop, RX_READ occurs within 2 cycles.
